// File: rtl/ssm_pkg.sv
// rtl/ssm_pkg.sv - shared FSM encoding, default dimensions and FP16 constants for the SSM sequencer
package ssm_pkg;
    localparam int B_DEF      = 1;
    localparam int H_DEF      = 4;
    localparam int P_DEF      = 4;
    localparam int N_DEF      = 4;
    localparam int DW_DEF     = 16;
    localparam int TO_CYC_DEF = 1024;

    localparam logic [15:0] FP16_ZERO = 16'h0000;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WAIT_TOK = 3'd1,
        S_LAUNCH   = 3'd2,
        S_RUN      = 3'd3,
        S_EMIT     = 3'd4,
        S_FIN      = 3'd5,
        S_ERR      = 3'd6
    } seq_state_t;
endpackage

// File: rtl/ssm_timeout_cnt.sv
// rtl/ssm_timeout_cnt.sv - saturating done-timeout counter for the SSM sequencer
module ssm_timeout_cnt
    import ssm_pkg::*;
#(
    parameter int TO_CYC = TO_CYC_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int W = $clog2(TO_CYC + 1);
    localparam logic [W-1:0] LAST = W'(TO_CYC - 1);

    logic [W-1:0] cnt;

    // Parks on LAST so a stalled datapath can never wrap back into a fresh window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (clear)
            cnt <= '0;
        else if (enable && cnt != LAST)
            cnt <= cnt + 1'b1;
    end

    // The cycle that sees LAST is the TO_CYC-th enabled cycle.
    assign expired = enable && (cnt == LAST);
endmodule

// File: rtl/ssm_seq_ctrl.sv
// rtl/ssm_seq_ctrl.sv - per-token sequencer driving an external SSM step datapath
module ssm_seq_ctrl
    import ssm_pkg::*;
#(
    parameter int B      = B_DEF,
    parameter int H      = H_DEF,
    parameter int P      = P_DEF,
    parameter int N      = N_DEF,
    parameter int DW     = DW_DEF,
    parameter int TO_CYC = TO_CYC_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [15:0]             cfg_len,
    input  logic                    seq_start,
    input  logic                    abort,
    input  logic                    tok_valid,
    output logic                    tok_ready,
    input  logic [B*H*DW-1:0]       tok_dt,
    input  logic [B*H*DW-1:0]       tok_dA,
    input  logic [B*N*DW-1:0]       tok_B,
    input  logic [B*N*DW-1:0]       tok_C,
    input  logic [B*H*P*DW-1:0]     tok_x,
    output logic                    ssm_start,
    input  logic                    ssm_done,
    output logic [B*H*DW-1:0]       ssm_dt,
    output logic [B*H*DW-1:0]       ssm_dA,
    output logic [B*N*DW-1:0]       ssm_B,
    output logic [B*N*DW-1:0]       ssm_C,
    output logic [B*H*P*DW-1:0]     ssm_x,
    output logic [B*H*P*N*DW-1:0]   ssm_h_prev,
    input  logic [B*H*P*N*DW-1:0]   ssm_h_new,
    input  logic [B*H*P*DW-1:0]     ssm_y,
    output logic                    y_valid,
    input  logic                    y_ready,
    output logic [B*H*P*DW-1:0]     y_data,
    output logic                    busy,
    output logic                    seq_done,
    output logic                    err_timeout,
    output logic [15:0]             tok_idx
);
    localparam logic [DW-1:0] ZERO_WORD = DW'(FP16_ZERO);

    seq_state_t                state;
    logic [15:0]               len_q;
    logic [B*H*P*N*DW-1:0]     h_state;
    logic [15:0]               tok_next;
    logic                      to_expired;

    assign tok_next = tok_idx + 16'd1;

    // Status strobes decode straight from the state flops so reset removes them without waiting for a clock.
    assign tok_ready   = (state == S_WAIT_TOK);
    assign ssm_start   = (state == S_LAUNCH);
    assign y_valid     = (state == S_EMIT);
    assign seq_done    = (state == S_FIN);
    assign err_timeout = (state == S_ERR);
    assign busy        = (state != S_IDLE) && (state != S_ERR);

    ssm_timeout_cnt #(.TO_CYC(TO_CYC)) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clear   (state == S_LAUNCH),
        .enable  (state == S_RUN),
        .expired (to_expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            len_q      <= '0;
            tok_idx    <= '0;
            h_state    <= '0;
            ssm_dt     <= '0;
            ssm_dA     <= '0;
            ssm_B      <= '0;
            ssm_C      <= '0;
            ssm_x      <= '0;
            ssm_h_prev <= '0;
            y_data     <= '0;
        end else if (abort) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE, S_ERR: begin
                    if (seq_start) begin
                        len_q   <= cfg_len;
                        tok_idx <= '0;
                        state   <= (cfg_len == 16'd0) ? S_FIN : S_WAIT_TOK;
                    end
                end
                S_WAIT_TOK: begin
                    if (tok_valid) begin
                        ssm_dt     <= tok_dt;
                        ssm_dA     <= tok_dA;
                        ssm_B      <= tok_B;
                        ssm_C      <= tok_C;
                        ssm_x      <= tok_x;
                        // First token of a sequence starts from a cleared recurrent state.
                        ssm_h_prev <= (tok_idx == 16'd0) ? {(B*H*P*N){ZERO_WORD}} : h_state;
                        state      <= S_LAUNCH;
                    end
                end
                S_LAUNCH: state <= S_RUN;
                S_RUN: begin
                    if (ssm_done) begin
                        y_data  <= ssm_y;
                        h_state <= ssm_h_new;
                        state   <= S_EMIT;
                    end else if (to_expired) begin
                        state <= S_ERR;
                    end
                end
                S_EMIT: begin
                    if (y_ready) begin
                        tok_idx <= tok_next;
                        state   <= (tok_next == len_q) ? S_FIN : S_WAIT_TOK;
                    end
                end
                S_FIN:   state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ssm_seq_ctrl.sv
// tb/tb_ssm_seq_ctrl.sv - self-checking bench for ssm_seq_ctrl with a behavioural datapath model
module tb_ssm_seq_ctrl;
    localparam int B = 1, H = 4, P = 4, N = 4, DW = 16, TO = 16;
    localparam int HW = B*H*DW, NW = B*N*DW, XW = B*H*P*DW, SW = B*H*P*N*DW;

    logic clk, rst;
    logic [15:0] cfg_len, tok_idx;
    logic seq_start, abort, tok_valid, tok_ready, ssm_start, ssm_done;
    logic y_valid, y_ready, busy, seq_done, err_timeout;
    logic [HW-1:0] tok_dt, tok_dA, ssm_dt, ssm_dA;
    logic [NW-1:0] tok_B, tok_C, ssm_B, ssm_C;
    logic [XW-1:0] tok_x, ssm_x, ssm_y, y_data;
    logic [SW-1:0] ssm_h_prev, ssm_h_new;

    ssm_seq_ctrl #(.B(B), .H(H), .P(P), .N(N), .DW(DW), .TO_CYC(TO)) dut (
        .clk(clk), .rst(rst), .cfg_len(cfg_len), .seq_start(seq_start), .abort(abort),
        .tok_valid(tok_valid), .tok_ready(tok_ready), .tok_dt(tok_dt), .tok_dA(tok_dA),
        .tok_B(tok_B), .tok_C(tok_C), .tok_x(tok_x), .ssm_start(ssm_start), .ssm_done(ssm_done),
        .ssm_dt(ssm_dt), .ssm_dA(ssm_dA), .ssm_B(ssm_B), .ssm_C(ssm_C), .ssm_x(ssm_x),
        .ssm_h_prev(ssm_h_prev), .ssm_h_new(ssm_h_new), .ssm_y(ssm_y), .y_valid(y_valid),
        .y_ready(y_ready), .y_data(y_data), .busy(busy), .seq_done(seq_done),
        .err_timeout(err_timeout), .tok_idx(tok_idx)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [HW-1:0] dt, da;
        logic [NW-1:0] b, c;
        logic [XW-1:0] x;
        logic [SW-1:0] hp;
    } tok_t;

    typedef struct {
        int len, lat, stall, exp_beats, exp_starts;
    } vec_t;

    int   vectors = 0, miscompares = 0;
    tok_t sent_q[$];
    tok_t mt;
    logic [XW-1:0] last_x;
    int   dp_lat, dp_cnt, start_cnt, done_cnt;
    bit   dp_en, dp_pend, spur_req, chk_next;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_wide(input string name, input logic [SW-1:0] act, input logic [SW-1:0] exp);
        int lane;
        vectors++;
        if (act !== exp) begin
            miscompares++;
            lane = 0;
            for (int i = SW/DW - 1; i >= 0; i--)
                if (act[i*DW +: DW] !== exp[i*DW +: DW]) lane = i;
            $display("FAIL %s: lane %0d got %h expected %h", name, lane, act[lane*DW +: DW], exp[lane*DW +: DW]);
        end
    endtask

    // Datapath contract used throughout: y echoes x, every state lane becomes 0x3C00 ^ x[15:0].
    function automatic logic [SW-1:0] hnew_of(input logic [XW-1:0] x);
        logic [SW-1:0] r;
        for (int i = 0; i < SW/DW; i++) r[i*DW +: DW] = 16'h3C00 ^ x[15:0];
        return r;
    endfunction

    function automatic logic [255:0] rnd256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        dp_pend = 0; dp_cnt = 0; start_cnt = 0; done_cnt = 0; chk_next = 0;
        ssm_done = 0; ssm_y = '0; ssm_h_new = '0;
        forever begin
            @(negedge clk);
            ssm_done = 1'b0;
            if (seq_done) done_cnt++;
            if (chk_next) begin
                chk("ssm_start_one_cycle", ssm_start, 0);
                chk_next = 0;
            end
            if (spur_req) begin
                ssm_done = 1'b1;
                ssm_y = ~ssm_x;
                spur_req = 0;
            end
            if (dp_pend) begin
                dp_cnt--;
                if (dp_cnt <= 0) begin
                    dp_pend = 0;
                    if (dp_en) begin
                        ssm_done  = 1'b1;
                        ssm_y     = ssm_x;
                        ssm_h_new = hnew_of(ssm_x);
                    end
                end
            end
            if (ssm_start) begin
                start_cnt++;
                dp_pend = 1; dp_cnt = dp_lat; chk_next = 1;
                if (sent_q.size() == 0) begin
                    chk("start_without_token", 1, 0);
                end else begin
                    mt = sent_q.pop_front();
                    chk("ssm_x", ssm_x, mt.x);
                    chk("ssm_dt", ssm_dt, mt.dt);
                    chk("ssm_dA", ssm_dA, mt.da);
                    chk("ssm_B", ssm_B, mt.b);
                    chk("ssm_C", ssm_C, mt.c);
                    chk_wide("ssm_h_prev", ssm_h_prev, mt.hp);
                end
            end
        end
    end

    task automatic start_seq(input logic [15:0] len);
        cfg_len = len;
        seq_start = 1'b1;
        tick();
        seq_start = 1'b0;
    endtask

    task automatic send_tok(input int k, input bit rnd, output logic [XW-1:0] x_out);
        tok_t t;
        int n;
        logic [255:0] r;
        r = rnd256(); t.dt = r[HW-1:0]; t.da = r[2*HW-1:HW]; t.b = r[HW*2+NW-1:HW*2]; t.c = r[HW*2+2*NW-1:HW*2+NW];
        if (rnd) t.x = rnd256();
        else for (int i = 0; i < XW/DW; i++) t.x[i*DW +: DW] = 16'(k);
        t.hp = (k == 0) ? '0 : hnew_of(last_x);
        if (rnd) repeat ($urandom_range(0, 2)) tick();
        tok_dt = t.dt; tok_dA = t.da; tok_B = t.b; tok_C = t.c; tok_x = t.x;
        tok_valid = 1'b1;
        n = 0;
        while (!tok_ready && n < 100) begin tick(); n++; end
        chk("tok_ready_wait", tok_ready, 1);
        chk("tok_idx", tok_idx, 256'(k));
        sent_q.push_back(t);
        tick();
        tok_valid = 1'b0;
        r = rnd256(); tok_x = r; tok_dt = r[HW-1:0]; tok_B = r[HW+NW-1:HW];
        last_x = t.x;
        x_out = t.x;
    endtask

    task automatic recv_y(input logic [XW-1:0] exp_x, input int stall, input bit jit, output bit got);
        int n = 0;
        got = 0;
        while (!y_valid && n < 64) begin tick(); n++; end
        chk("y_valid_wait", y_valid, 1);
        if (!y_valid) return;
        chk("y_data", y_data, exp_x);
        chk("tok_ready_in_emit", tok_ready, 0);
        for (int s = 0; s < stall; s++) begin
            if (jit) begin
                seq_start = 1'($urandom_range(0, 1));
                cfg_len = 16'($urandom);
            end
            tick();
            seq_start = 1'b0;
            chk("y_valid_hold", y_valid, 1);
            chk("y_data_hold", y_data, exp_x);
            chk("tok_ready_hold", tok_ready, 0);
        end
        y_ready = 1'b1;
        tick();
        y_ready = 1'b0;
        got = 1;
    endtask

    task automatic end_seq(input logic [15:0] len);
        chk("seq_done_pulse", seq_done, 1);
        chk("tok_idx_final", tok_idx, 256'(len));
        tick();
        chk("seq_done_clear", seq_done, 0);
        chk("busy_after_fin", busy, 0);
    endtask

    task automatic run_seq(input int len, input int lat, input int stall, input bit rnd,
                           output int beats, output int starts);
        logic [XW-1:0] x;
        bit got;
        int s0, d0;
        s0 = start_cnt; d0 = done_cnt; beats = 0;
        dp_lat = lat;
        start_seq(16'(len));
        for (int k = 0; k < len; k++) begin
            send_tok(k, rnd, x);
            recv_y(x, rnd ? $urandom_range(0, stall) : stall, rnd, got);
            if (got) beats++;
        end
        end_seq(16'(len));
        starts = start_cnt - s0;
        chk("seq_done_count", 256'(done_cnt - d0), 1);
    endtask

    vec_t tbl[5];

    initial begin
        logic [XW-1:0] x;
        bit got;
        int beats, starts, s0, d0, len;

        tbl[0] = '{len: 3, lat: 5, stall: 0, exp_beats: 3, exp_starts: 3};
        tbl[1] = '{len: 1, lat: 1, stall: 0, exp_beats: 1, exp_starts: 1};
        tbl[2] = '{len: 2, lat: 3, stall: 2, exp_beats: 2, exp_starts: 2};
        tbl[3] = '{len: 4, lat: 1, stall: 1, exp_beats: 4, exp_starts: 4};
        tbl[4] = '{len: 5, lat: 8, stall: 3, exp_beats: 5, exp_starts: 5};

        rst = 1'b1; cfg_len = '0; seq_start = 0; abort = 0; tok_valid = 0; y_ready = 0;
        tok_dt = '0; tok_dA = '0; tok_B = '0; tok_C = '0; tok_x = '0; last_x = '0;
        dp_en = 1; dp_lat = 3; spur_req = 0;
        repeat (3) tick();
        chk("rst_busy", busy, 0);
        chk("rst_tok_ready", tok_ready, 0);
        chk("rst_y_valid", y_valid, 0);
        chk("rst_ssm_start", ssm_start, 0);
        chk("rst_err", err_timeout, 0);
        chk("rst_tok_idx", tok_idx, 0);
        chk("rst_ssm_x", ssm_x, 0);
        chk("rst_y_data", y_data, 0);
        chk_wide("rst_h_prev", ssm_h_prev, '0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 5; i++) begin
            run_seq(tbl[i].len, tbl[i].lat, tbl[i].stall, 0, beats, starts);
            chk("tbl_beats", 256'(beats), 256'(tbl[i].exp_beats));
            chk("tbl_starts", 256'(starts), 256'(tbl[i].exp_starts));
        end

        for (int i = 0; i < 6; i++) begin
            len = $urandom_range(1, 6);
            run_seq(len, $urandom_range(1, 8), 4, 1, beats, starts);
            chk("rnd_beats", 256'(beats), 256'(len));
            chk("rnd_starts", 256'(starts), 256'(len));
        end

        // Long backpressure with ignored seq_start pulses.
        dp_lat = 2;
        start_seq(16'd1);
        send_tok(0, 1, x);
        recv_y(x, 20, 1, got);
        end_seq(16'd1);

        // Datapath silent: timeout, then recovery on seq_start.
        dp_en = 0; dp_lat = 3;
        start_seq(16'd2);
        send_tok(0, 1, x);
        chk("to_launch", ssm_start, 1);
        repeat (16) tick();
        chk("to_not_yet", err_timeout, 0);
        chk("to_busy_run", busy, 1);
        tick();
        chk("to_err_set", err_timeout, 1);
        chk("to_busy_err", busy, 0);
        repeat (5) tick();
        chk("to_err_hold", err_timeout, 1);
        dp_en = 1;
        start_seq(16'd1);
        chk("to_err_clear", err_timeout, 0);
        chk("to_restart_ready", tok_ready, 1);
        send_tok(0, 1, x);
        recv_y(x, 0, 0, got);
        end_seq(16'd1);

        // Abort during RUN of token 1, then a spurious done.
        dp_lat = 8;
        s0 = start_cnt; d0 = done_cnt;
        start_seq(16'd3);
        send_tok(0, 1, x);
        recv_y(x, 0, 0, got);
        send_tok(1, 1, x);
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_tok_ready", tok_ready, 0);
        chk("abort_seq_done", seq_done, 0);
        spur_req = 1;
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("abort_y_valid", y_valid, 0);
            chk("abort_idle", busy, 0);
        end
        chk("abort_starts", 256'(start_cnt - s0), 2);
        chk("abort_no_done", 256'(done_cnt - d0), 0);

        // Zero-length sequence.
        s0 = start_cnt;
        start_seq(16'd0);
        chk("len0_done", seq_done, 1);
        chk("len0_tok_ready", tok_ready, 0);
        tick();
        chk("len0_done_clear", seq_done, 0);
        chk("len0_idle", busy, 0);
        chk("len0_no_start", 256'(start_cnt - s0), 0);

        // Maximum length: no early finish after a couple of tokens.
        dp_lat = 2;
        start_seq(16'hFFFF);
        for (int k = 0; k < 2; k++) begin
            send_tok(k, 1, x);
            recv_y(x, 0, 0, got);
        end
        chk("max_no_fin", seq_done, 0);
        chk("max_wait_tok", tok_ready, 1);
        chk("max_tok_idx", tok_idx, 2);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("max_abort_idle", busy, 0);

        // Asynchronous reset during LAUNCH.
        start_seq(16'd2);
        send_tok(0, 1, x);
        chk("arst_launch_seen", ssm_start, 1);
        #1 rst = 1'b1;
        #1;
        chk("arst_ssm_start", ssm_start, 0);
        chk("arst_busy", busy, 0);
        chk("arst_ssm_x", ssm_x, 0);
        chk("arst_ssm_dt", ssm_dt, 0);
        tick();
        rst = 1'b0;
        repeat (12) tick();

        // Asynchronous reset during EMIT.
        dp_lat = 2;
        start_seq(16'd2);
        send_tok(0, 1, x);
        begin
            int n = 0;
            while (!y_valid && n < 64) begin tick(); n++; end
        end
        chk("arst_emit_seen", y_valid, 1);
        #1 rst = 1'b1;
        #1;
        chk("arst_y_valid", y_valid, 0);
        chk("arst_y_data", y_data, 0);
        chk("arst_tok_idx", tok_idx, 0);
        chk_wide("arst_h_prev", ssm_h_prev, '0);
        tick();
        rst = 1'b0;
        repeat (4) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/ssm_seq_ctrl.md
SSM_SEQ_CTRL -- requirements
Module: ssm_seq_ctrl

Interface
REQ-001 Parameters SHALL be: B, default 1, batch; H, default 4, heads; P, default 4, head dim; N, default 4, state dim; DW, default 16, FP16 word width; TO_CYC, default 1024, done-timeout cycles.
REQ-002 clk  in  1  single clock; all state SHALL update on the rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 cfg_len  in  16  number of tokens in the sequence; sampled on seq_start.
REQ-005 seq_start  in  1  one-cycle pulse; begins a sequence when in IDLE.
REQ-006 abort  in  1  synchronous abort request.
REQ-007 tok_valid / tok_ready  in / out  1 / 1  token operand handshake.
REQ-008 tok_dt, tok_dA  in  B*H*DW  per-head operands.
REQ-009 tok_B, tok_C  in  B*N*DW  input and output projections.
REQ-010 tok_x  in  B*H*P*DW  token input.
REQ-011 ssm_start  out  1  start pulse to the SSM step datapath.
REQ-012 ssm_done  in  1  completion from the datapath.
REQ-013 ssm_dt, ssm_dA, ssm_B, ssm_C, ssm_x  out  widths per REQ-008 to REQ-010  registered operands.
REQ-014 ssm_h_prev  out  B*H*P*N*DW  state fed to the datapath.
REQ-015 ssm_h_new, ssm_y  in  B*H*P*N*DW, B*H*P*DW  datapath results.
REQ-016 y_valid / y_ready  out / in  1 / 1  output handshake.
REQ-017 y_data  out  B*H*P*DW  captured ssm_y.
REQ-018 busy, seq_done, err_timeout  out  1 each  status outputs.
REQ-019 tok_idx  out  16  index of the current token.

Function
REQ-020 The FSM SHALL have the states IDLE, WAIT_TOK, LAUNCH, RUN, EMIT, FIN and ERR.
REQ-021 IDLE SHALL go to WAIT_TOK on seq_start with cfg_len != 0; with cfg_len == 0 it SHALL go to FIN and touch no datapath signal.
REQ-022 tok_ready SHALL equal (state == WAIT_TOK), combinationally.
REQ-023 On a tok_valid && tok_ready cycle, the token operands SHALL be registered into the ssm_* outputs and the FSM SHALL go to LAUNCH.
REQ-024 LAUNCH SHALL assert ssm_start for exactly one cycle, then go to RUN; the timeout counter SHALL clear in LAUNCH.
REQ-025 In RUN, ssm_done SHALL cause ssm_y to be captured into y_data and ssm_h_new into the state register, and the FSM SHALL go to EMIT.
REQ-026 In RUN, TO_CYC cycles without ssm_done SHALL cause the FSM to go to ERR.
REQ-027 ssm_h_prev SHALL be all-zero for token 0 and the state register for every later token; ssm_h_prev SHALL be stable from LAUNCH through RUN.
REQ-028 y_valid SHALL equal (state == EMIT).
REQ-029 In EMIT, y_data SHALL hold until y_valid && y_ready (backpressure unbounded).
REQ-030 On that EMIT handshake, tok_idx SHALL increment; the FSM SHALL go to FIN if the new tok_idx == cfg_len latched, otherwise to WAIT_TOK.
REQ-031 FIN SHALL pulse seq_done for one cycle, then go to IDLE.
REQ-032 ERR SHALL hold err_timeout = 1 until the next seq_start, which SHALL clear it and restart as in IDLE.
REQ-033 abort SHALL force IDLE from any state on the next edge, with no seq_done and no further ssm_start; abort SHALL have priority over all other transitions.
REQ-034 seq_start outside IDLE and ERR SHALL be ignored.
REQ-035 ssm_done outside RUN SHALL be ignored.
REQ-036 busy SHALL equal (state != IDLE && state != ERR).
REQ-037 The timeout counter SHALL saturate and SHALL NOT wrap.
REQ-038 tok_idx SHALL be 16-bit, cleared on sequence start; cfg_len = 65535 SHALL be supported without wrap-induced early finish.

Reset
REQ-039 rst SHALL force IDLE, and SHALL clear every output and register to 0, including ssm_* operands, the state register, tok_idx and err_timeout.
REQ-040 rst asserted mid-sequence SHALL drop ssm_start and y_valid immediately, asynchronously.

Structure
REQ-041 The FSM state encoding, the default dimension constants and the FP16 zero constant SHALL be defined in a shared package, ssm_pkg.
REQ-042 The timeout counter SHALL be a sub-module, ssm_timeout_cnt, with clear, enable and expired ports.
REQ-043 ssm_seq_ctrl SHALL instantiate no arithmetic; the datapath is external.

Verification
REQ-044 cfg_len=3, model datapath returning done 5 cycles after start, y = token index in every lane -> three y beats 0,1,2; seq_done once; ssm_h_prev zero for token 0 only.
REQ-045 Token 1's ssm_h_prev equals token 0's ssm_h_new: model h_new = 0x3C00 everywhere -> token 1 drives 0x3C00 in every lane.
REQ-046 y_ready held low 20 cycles in EMIT -> y_data stable and tok_ready low throughout.
REQ-047 Datapath never asserts done, TO_CYC=16 -> err_timeout set 16 cycles after LAUNCH; a following seq_start clears it.
REQ-048 abort asserted during RUN on token 1 -> IDLE next cycle; no seq_done; a spurious ssm_done afterwards is ignored.
REQ-049 cfg_len=0 -> seq_done pulse and ssm_start never asserted; rst pulsed mid-RUN -> all outputs 0 asynchronously.
